rom_loader: RTL and testbench

//  Byte-stream program loader; the writer side of the miniRV instruction-ROM load port.

---
 rtl/rom_loader.sv | 188 ++++++++++++++++++
 tb/tb_rom_loader.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/rom_loader.sv
// ---------------------------------------------------------------------------
// rom_loader
//   Byte-stream program loader for the miniRV instruction ROM load port.
//   Receives a length-prefixed, little-endian byte stream over a valid/ready
//   handshake, packs the bytes into 32-bit words and writes each word into
//   the ROM. The core is held in reset until the full image has been written.
//
// Ports
//   clk         clock, rising edge
//   reset       asynchronous, active-low reset
//   start       1-cycle pulse, restarts a load from DONE or ERR
//   in_valid    source presents a byte on in_data
//   in_data     stream byte
//   in_ready    loader accepts in_data this cycle
//   rom_wen     ROM write strobe, one cycle per word
//   rom_addr    ROM byte address (word aligned)
//   rom_wdata   ROM write data
//   core_reset  active-high hold-in-reset for the core, low only when done
//   done        image fully written
//   error       header word count exceeded MAX_WORDS
// ---------------------------------------------------------------------------
module rom_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 16384
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        rom_wen,
    output logic [31:0] rom_addr,
    output logic [31:0] rom_wdata,
    output logic        core_reset,
    output logic        done,
    output logic        error
);

    localparam int          IDX_W   = $clog2(MAX_WORDS) + 1;
    localparam logic [31:0] MAX_W32 = 32'(MAX_WORDS);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        DATA  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         byte_cnt_q, byte_cnt_d;
    logic [23:0]        shift_q, shift_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   n_q, n_d;
    logic [31:0]        rom_addr_q, rom_addr_d;
    logic [31:0]        rom_wdata_q, rom_wdata_d;
    logic               in_ready_q, in_ready_d;
    logic               rom_wen_q, rom_wen_d;
    logic               core_reset_q, core_reset_d;
    logic               done_q, done_d;
    logic               error_q, error_d;

    logic               xfer;
    logic [31:0]        word;
    logic [IDX_W-1:0]   idx_inc;
    logic [31:0]        addr_off;

    assign xfer     = in_valid && in_ready_q;
    // Earlier bytes sit in shift_q with the first byte in the low lane, so
    // the arriving 4th byte completes the little-endian word on top.
    assign word     = {in_data, shift_q};
    assign idx_inc  = idx_q + 1'b1;
    assign addr_off = {{(30 - IDX_W){1'b0}}, idx_q, 2'b00};

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        shift_d     = shift_q;
        idx_d       = idx_q;
        n_d         = n_q;
        rom_addr_d  = rom_addr_q;
        rom_wdata_d = rom_wdata_q;

        case (state_q)
            IDLE: state_d = HDR;

            HDR: begin
                if (xfer) begin
                    shift_d    = {in_data, shift_q[23:8]};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        shift_d = '0;
                        // Range check uses the full 32-bit count; only a
                        // count that passes is truncated into n_q.
                        if (word > MAX_W32) begin
                            state_d = ERR;
                        end else if (word == 32'd0) begin
                            state_d = DONE;
                        end else begin
                            state_d = DATA;
                            n_d     = word[IDX_W-1:0];
                            idx_d   = '0;
                        end
                    end
                end
            end

            DATA: begin
                if (xfer) begin
                    shift_d    = {in_data, shift_q[23:8]};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        shift_d     = '0;
                        rom_wdata_d = word;
                        rom_addr_d  = BASE_ADDR + addr_off;
                        state_d     = WRITE;
                    end
                end
            end

            WRITE: begin
                idx_d   = idx_inc;
                state_d = (idx_inc == n_q) ? DONE : DATA;
            end

            DONE, ERR: begin
                if (start) begin
                    state_d    = HDR;
                    byte_cnt_d = '0;
                    shift_d    = '0;
                    idx_d      = '0;
                    rom_addr_d = BASE_ADDR;
                end
            end

            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with
        // the state register without any combinational path to the ports.
        in_ready_d   = (state_d == HDR) || (state_d == DATA);
        rom_wen_d    = (state_d == WRITE);
        done_d       = (state_d == DONE);
        error_d      = (state_d == ERR);
        core_reset_d = (state_d != DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            byte_cnt_q   <= '0;
            shift_q      <= '0;
            idx_q        <= '0;
            n_q          <= '0;
            rom_addr_q   <= BASE_ADDR;
            rom_wdata_q  <= '0;
            in_ready_q   <= 1'b0;
            rom_wen_q    <= 1'b0;
            core_reset_q <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            shift_q      <= shift_d;
            idx_q        <= idx_d;
            n_q          <= n_d;
            rom_addr_q   <= rom_addr_d;
            rom_wdata_q  <= rom_wdata_d;
            in_ready_q   <= in_ready_d;
            rom_wen_q    <= rom_wen_d;
            core_reset_q <= core_reset_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign rom_wen    = rom_wen_q;
    assign rom_addr   = rom_addr_q;
    assign rom_wdata  = rom_wdata_q;
    assign core_reset = core_reset_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_rom_loader.sv
// ---------------------------------------------------------------------------
// tb_rom_loader
//   Directed bench for rom_loader: byte streams with hand-computed ROM writes.
// ---------------------------------------------------------------------------
module tb_rom_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        rom_wen;
    logic [31:0] rom_addr;
    logic [31:0] rom_wdata;
    logic        core_reset;
    logic        done;
    logic        error;

    int          tests_run  = 0;
    int          tests_fail = 0;
    int          rdy_in_write = 0;
    logic [31:0] wa [$];
    logic [31:0] wd [$];

    rom_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .rom_wen    (rom_wen),
        .rom_addr   (rom_addr),
        .rom_wdata  (rom_wdata),
        .core_reset (core_reset),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    // Write monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rom_wen) begin
            wa.push_back(rom_addr);
            wd.push_back(rom_wdata);
            if (in_ready) rdy_in_write++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("ready_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'hxx;
        repeat (gap) @(posedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_reset_vals(input string t);
        check({t, "_wen"},   {31'd0, rom_wen},    32'd0);
        check({t, "_addr"},  rom_addr,            32'h0);
        check({t, "_wdata"}, rom_wdata,           32'h0);
        check({t, "_rdy"},   {31'd0, in_ready},   32'd0);
        check({t, "_crst"},  {31'd0, core_reset}, 32'd1);
        check({t, "_done"},  {31'd0, done},       32'd0);
        check({t, "_err"},   {31'd0, error},      32'd0);
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        #23;
        check_reset_vals("rst");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("idle_to_hdr_rdy", {31'd0, in_ready}, 32'd1);

        // 1: two-word image, back-to-back bytes, latency checks
        wa.delete(); wd.delete();
        send_word(32'd2, 0);
        send_word(32'h0000_0093, 0);
        @(negedge clk);
        check("t1_wen_lat", {31'd0, rom_wen},  32'd1);
        check("t1_rdy_wr",  {31'd0, in_ready}, 32'd0);
        send_word(32'h1234_5537, 0);
        @(negedge clk);
        check("t1_wen2",    {31'd0, rom_wen}, 32'd1);
        check("t1_done_early", {31'd0, done}, 32'd0);
        @(negedge clk);
        check("t1_done",    {31'd0, done},       32'd1);
        check("t1_crst",    {31'd0, core_reset}, 32'd0);
        check("t1_wen_off", {31'd0, rom_wen},    32'd0);
        check("t1_nwr",     wa.size(),           32'd2);
        if (wa.size() == 2) begin
            check("t1_a0", wa[0], 32'h0);
            check("t1_d0", wd[0], 32'h0000_0093);
            check("t1_a1", wa[1], 32'h4);
            check("t1_d1", wd[1], 32'h1234_5537);
        end
        check("t1_hold_addr",  rom_addr,  32'h4);
        check("t1_hold_wdata", rom_wdata, 32'h1234_5537);

        // 2: same image with in_valid toggling
        pulse_start();
        check("t2_done_clr", {31'd0, done}, 32'd0);
        wa.delete(); wd.delete();
        rdy_in_write = 0;
        send_word(32'd2, 1);
        send_word(32'h0000_0093, 1);
        send_word(32'h1234_5537, 1);
        repeat (3) @(negedge clk);
        check("t2_nwr", wa.size(), 32'd2);
        if (wa.size() == 2) begin
            check("t2_a0", wa[0], 32'h0);
            check("t2_d0", wd[0], 32'h0000_0093);
            check("t2_a1", wa[1], 32'h4);
            check("t2_d1", wd[1], 32'h1234_5537);
        end
        check("t2_rdy_in_write", rdy_in_write, 32'd0);
        check("t2_done", {31'd0, done}, 32'd1);

        // 3: empty image
        pulse_start();
        wa.delete(); wd.delete();
        send_word(32'd0, 0);
        @(negedge clk);
        check("t3_done", {31'd0, done},       32'd1);
        check("t3_crst", {31'd0, core_reset}, 32'd0);
        check("t3_nwr",  wa.size(),           32'd0);

        // 4: oversize header 16385
        pulse_start();
        wa.delete(); wd.delete();
        send_word(32'd16385, 0);
        @(negedge clk);
        check("t4_err",  {31'd0, error},      32'd1);
        check("t4_rdy",  {31'd0, in_ready},   32'd0);
        check("t4_crst", {31'd0, core_reset}, 32'd1);
        check("t4_done", {31'd0, done},       32'd0);
        repeat (3) @(negedge clk);
        check("t4_nwr",  wa.size(),           32'd0);
        pulse_start();
        check("t4_err_clr", {31'd0, error},    32'd0);
        check("t4_hdr_rdy", {31'd0, in_ready}, 32'd1);

        // 5: reset in the middle of word 1 of a 3-word load
        wa.delete(); wd.delete();
        send_word(32'd3, 0);
        send_word(32'h4433_2211, 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_vals("t5_rst");
        @(negedge clk);
        reset = 1'b1;
        wa.delete(); wd.delete();
        send_word(32'd1, 0);
        send_word(32'hDDCC_BBAA, 0);
        repeat (2) @(negedge clk);
        check("t5_nwr", wa.size(), 32'd1);
        if (wa.size() == 1) begin
            check("t5_a0", wa[0], 32'h0);
            check("t5_d0", wd[0], 32'hDDCC_BBAA);
        end
        check("t5_done", {31'd0, done}, 32'd1);

        // 6: reload from DONE
        pulse_start();
        check("t6_done_clr", {31'd0, done},       32'd0);
        check("t6_crst_hi",  {31'd0, core_reset}, 32'd1);
        wa.delete(); wd.delete();
        send_word(32'd1, 0);
        send_word(32'hDEAD_BEEF, 0);
        repeat (2) @(negedge clk);
        check("t6_nwr", wa.size(), 32'd1);
        if (wa.size() == 1) begin
            check("t6_a0", wa[0], 32'h0);
            check("t6_d0", wd[0], 32'hDEAD_BEEF);
        end
        check("t6_done", {31'd0, done}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
        $finish;
    end

endmodule
